// File: rtl/ucsbece154b_perf_pkg.sv
// Shared constants, FSM encoding and small decode helpers for the
// ucsbece154b performance-counter block.
package ucsbece154b_perf_pkg;

  localparam int NUM_CNT = 6;

  localparam logic [2:0] ADDR_CYC     = 3'd0;
  localparam logic [2:0] ADDR_INSTR   = 3'd1;
  localparam logic [2:0] ADDR_BR      = 3'd2;
  localparam logic [2:0] ADDR_BRMISS  = 3'd3;
  localparam logic [2:0] ADDR_JMP     = 3'd4;
  localparam logic [2:0] ADDR_JMPMISS = 3'd5;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [31:0] INSTR_NOP = 32'h00000013;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } perf_state_t;

  // A bubble (all zeros) or the canonical NOP is not a real instruction.
  function automatic logic instr_valid(input logic [31:0] instr);
    return (instr != 32'd0) && (instr != INSTR_NOP);
  endfunction

  function automatic logic is_jump(input logic [6:0] op);
    return (op == OP_JAL) || (op == OP_JALR);
  endfunction

  function automatic logic [1:0] slot_sum(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/ucsbece154b_perf_counters_if.sv
// Pipeline observation signals and counter read port of the perf-counter block.
// There is no handshake: inputs are sampled every clock, rdata_o lags raddr_i by one edge.
interface ucsbece154b_perf_counters_if
  import ucsbece154b_perf_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic             clear_i;
  logic [31:0]      InstrD_i;
  logic [31:0]      InstrD2_i;
  logic [6:0]       opE_i;
  logic [6:0]       opE2_i;
  logic             Mispredict_i;
  logic             Mispredict2_i;
  logic             BranchTakenF_i;
  logic             BranchTakenF2_i;
  logic [31:0]      PCF_i;
  logic [31:0]      PCF2_i;
  logic [31:0]      InstrF_i;
  logic [31:0]      InstrF2_i;
  logic [2:0]       raddr_i;
  logic [WIDTH-1:0] rdata_o;
  logic             done_o;
  logic             timeout_o;
  perf_state_t      state_dbg;

  modport master (
    output clear_i, InstrD_i, InstrD2_i, opE_i, opE2_i,
           Mispredict_i, Mispredict2_i, BranchTakenF_i, BranchTakenF2_i,
           PCF_i, PCF2_i, InstrF_i, InstrF2_i, raddr_i,
    input  rdata_o, done_o, timeout_o, state_dbg
  );

  modport slave (
    input  clear_i, InstrD_i, InstrD2_i, opE_i, opE2_i,
           Mispredict_i, Mispredict2_i, BranchTakenF_i, BranchTakenF2_i,
           PCF_i, PCF2_i, InstrF_i, InstrF2_i, raddr_i,
    output rdata_o, done_o, timeout_o, state_dbg
  );

endinterface

// File: rtl/ucsbece154b_sat_counter.sv
// WIDTH-bit event counter that adds 0..3 per cycle and sticks at all-ones
// instead of wrapping.
module ucsbece154b_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [1:0]       inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = {1'b0, count} + (WIDTH+1)'(inc);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (sum[WIDTH]) begin
      count <= '1;
    end else begin
      count <= sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/ucsbece154b_perf_counters.sv
// Dual-slot performance monitor: cycle/instruction/branch/jump counters, a
// registered read port, and program-completion detection (idle loop or cycle cap).
module ucsbece154b_perf_counters
  import ucsbece154b_perf_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MAX_CYCLES  = 500,
  parameter int HALT_CYCLES = 1
) (
  input logic                       clk,
  input logic                       reset,
  ucsbece154b_perf_counters_if.slave bus
);

  localparam int IW = (HALT_CYCLES < 1) ? 1 : $clog2(HALT_CYCLES + 1);
  localparam int EW = WIDTH + 32;

  perf_state_t      state_q;
  logic [31:0]      prev_pc_q;
  logic [31:0]      prev_pc2_q;
  logic [IW-1:0]    idle_cnt_q;
  logic             done_q;
  logic             timeout_q;
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_next;

  logic [WIDTH-1:0] cnt [NUM_CNT];
  logic [1:0]       inc [NUM_CNT];

  logic             count_en;
  logic             v1, v2, br1, br2, j1, j2;
  logic             idle, idle_done, cyc_done;
  logic [EW-1:0]    cyc_ext;

  always_comb begin
    count_en = (state_q == ST_RUN) && !bus.clear_i;
    v1  = instr_valid(bus.InstrD_i);
    v2  = instr_valid(bus.InstrD2_i);
    br1 = (bus.opE_i == OP_BRANCH);
    br2 = (bus.opE2_i == OP_BRANCH);
    j1  = is_jump(bus.opE_i);
    j2  = is_jump(bus.opE2_i);

    for (int k = 0; k < NUM_CNT; k++) inc[k] = 2'd0;
    if (count_en) begin
      inc[ADDR_CYC]     = 2'd1;
      inc[ADDR_INSTR]   = slot_sum(v1, v2);
      inc[ADDR_BR]      = slot_sum(br1, br2);
      inc[ADDR_BRMISS]  = slot_sum(br1 & bus.Mispredict_i, br2 & bus.Mispredict2_i);
      inc[ADDR_JMP]     = slot_sum(j1, j2);
      // A jump the predictor did not mark taken cost a redirect.
      inc[ADDR_JMPMISS] = slot_sum(j1 & ~bus.BranchTakenF_i, j2 & ~bus.BranchTakenF2_i);
    end
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    ucsbece154b_sat_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (bus.clear_i),
      .inc   (inc[g]),
      .count (cnt[g])
    );
  end

  // Completion checks look at this cycle as if it were already counted.
  always_comb begin
    idle = (bus.PCF_i == prev_pc_q) && (bus.PCF2_i == prev_pc2_q) &&
           (bus.InstrF_i == INSTR_NOP) && (bus.InstrF2_i == INSTR_NOP);
    idle_done = idle && ((int'(idle_cnt_q) + 1) >= HALT_CYCLES);
    cyc_ext   = EW'(cnt[ADDR_CYC]) + EW'(1);
    cyc_done  = (cyc_ext >= EW'(MAX_CYCLES));
  end

  always_comb begin
    rdata_next = '0;
    case (bus.raddr_i)
      ADDR_CYC:     rdata_next = cnt[ADDR_CYC];
      ADDR_INSTR:   rdata_next = cnt[ADDR_INSTR];
      ADDR_BR:      rdata_next = cnt[ADDR_BR];
      ADDR_BRMISS:  rdata_next = cnt[ADDR_BRMISS];
      ADDR_JMP:     rdata_next = cnt[ADDR_JMP];
      ADDR_JMPMISS: rdata_next = cnt[ADDR_JMPMISS];
      default:      rdata_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_INIT;
      prev_pc_q  <= '0;
      prev_pc2_q <= '0;
      idle_cnt_q <= '0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      rdata_q    <= '0;
    end else begin
      rdata_q <= rdata_next;
      if (bus.clear_i) begin
        state_q    <= ST_INIT;
        idle_cnt_q <= '0;
        done_q     <= 1'b0;
        timeout_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_INIT: begin
            prev_pc_q  <= bus.PCF_i;
            prev_pc2_q <= bus.PCF2_i;
            idle_cnt_q <= '0;
            state_q    <= ST_RUN;
          end
          ST_RUN: begin
            prev_pc_q  <= bus.PCF_i;
            prev_pc2_q <= bus.PCF2_i;
            idle_cnt_q <= idle ? (idle_cnt_q + IW'(1)) : '0;
            // A real idle loop wins over the cycle cap when both land together.
            if (idle_done) begin
              state_q   <= ST_HALTED;
              done_q    <= 1'b1;
              timeout_q <= 1'b0;
            end else if (cyc_done) begin
              state_q   <= ST_HALTED;
              done_q    <= 1'b1;
              timeout_q <= 1'b1;
            end
          end
          ST_HALTED: begin
            state_q <= ST_HALTED;
          end
          default: begin
            state_q <= ST_INIT;
          end
        endcase
      end
    end
  end

  assign bus.rdata_o   = rdata_q;
  assign bus.done_o    = done_q;
  assign bus.timeout_o = timeout_q;
  assign bus.state_dbg = state_q;

endmodule
